// File: rtl/contador_pkg.sv
// Shared definitions for the contador_regressivo down-counter:
// FSM state encoding and the default counter width.
package contador_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/contador_regressivo.sv
// contador_regressivo: loadable down-counter with enable, abort and done flag.
// All state updates on the falling edge of clock. Reset is synchronous and
// active-low, sampled on the same falling edge.
// Optional feature: define CONTADOR_REGRESSIVO_AUTO_RELOAD_EN to restart the
// countdown from the last loaded value each time DONE is reached.
//
// state | meaning
// IDLE  | waiting for load; Q holds, enable ignored
// COUNT | counting down one step per enabled edge
// DONE  | Q reached 0; lasts one cycle (or reloads when auto-reload is built)
module contador_regressivo
  import contador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] w_r_nxt;
`endif

  // Next-state and next-count decode; load beats abort beats normal operation.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
    w_r_nxt     = r_r;
`endif
    if (load) begin
      w_q_nxt     = D;
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
      w_r_nxt     = D;
`endif
      w_state_nxt = (D != '0) ? COUNT : DONE;
    end else if (abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        COUNT: begin
          if (enable) begin
            // Saturate at zero: a stray zero in COUNT just finishes.
            if (r_q != '0) w_q_nxt = r_q - WIDTH'(1);
            if (r_q <= WIDTH'(1)) w_state_nxt = DONE;
          end
        end
        DONE: begin
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
          // A zero reload value would finish instantly, so park in DONE instead.
          if (r_r != '0) begin
            w_q_nxt     = r_r;
            w_state_nxt = COUNT;
          end else begin
            w_state_nxt = DONE;
          end
`else
          w_state_nxt = IDLE;
`endif
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, synchronous active-low reset on the falling edge.
  always_ff @(negedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_q     <= '0;
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
      r_r     <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
      r_r     <= w_r_nxt;
`endif
    end
  end

  // Output decode straight from the registered state and count.
  always_comb begin
    Q    = r_q;
    busy = (r_state == COUNT);
    done = (r_state == DONE);
    zero = (r_q == '0);
  end

endmodule

// File: doc/contador_regressivo.md
CONTADOR_REGRESSIVO -- requirements
Module: contador_regressivo

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set counter width in bits; legal range 2..16.
REQ-002 clock  input  1  SHALL be the single clock; all state SHALL update on its falling edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-low reset, sampled on the falling edge of clock.
REQ-004 load  input  1  SHALL be active-high; loads D and starts a countdown.
REQ-005 D  input  WIDTH  SHALL be the start value, sampled only when load=1.
REQ-006 enable  input  1  SHALL be active-high; when 0 in COUNT, the count SHALL hold.
REQ-007 abort  input  1  SHALL be active-high; stops the countdown and keeps Q.
REQ-008 Q  output  WIDTH  SHALL be the registered count value.
REQ-009 busy  output  1  SHALL equal 1 exactly while the state is COUNT.
REQ-010 done  output  1  SHALL equal 1 exactly while the state is DONE.
REQ-011 zero  output  1  SHALL be combinational (Q == 0).

Function
REQ-012 FSM states SHALL be IDLE, COUNT and DONE; the sole reset state SHALL be IDLE.
REQ-013 Per-edge priority SHALL be reset > load > abort > normal operation.
REQ-014 load=1 in any state: Q<=D, reload register R<=D; next state COUNT if D!=0, else DONE.
REQ-015 COUNT with enable=1: Q<=Q-1; if Q==1, next state DONE (Q becomes 0 on the same edge).
REQ-016 COUNT with enable=0: Q and state hold.
REQ-017 abort=1 with load=0 in COUNT or DONE: next state IDLE, Q unchanged.
REQ-018 IDLE with load=0: Q and state hold; enable is ignored.
REQ-019 Latency: done SHALL rise on the edge after load plus D enabled edges; Q==D-k after k enabled edges.
REQ-020 Q SHALL never decrement below 0; no wrap-around from 0 to all-ones SHALL occur.
REQ-021 Without reload (see Configuration), DONE SHALL last exactly one cycle and then go to IDLE with Q=0.
REQ-022 load in the same cycle as a Q==1 decrement: load SHALL win; done SHALL NOT assert.

Reset
REQ-023 reset=0 SHALL force Q=0, R=0, state IDLE (busy=0, done=0, zero=1) at the next falling edge, including mid-countdown.
REQ-024 reset SHALL have no asynchronous effect; between edges, outputs hold.
REQ-025 After reset is released, the block SHALL idle until load=1.

Configuration
REQ-026 Macro CONTADOR_REGRESSIVO_AUTO_RELOAD_EN SHALL select the auto-reload feature.
REQ-027 Defined: from DONE, when load=0 and abort=0, Q<=R and the next state is COUNT; if R==0, the block SHALL remain in DONE with done held at 1.
REQ-028 Undefined: R and its reload path SHALL be absent; DONE SHALL always go to IDLE (REQ-021).

Structure
REQ-029 Package contador_pkg SHALL hold the state typedef (IDLE=2'b00, COUNT=2'b01, DONE=2'b10) and the WIDTH default constant.
REQ-030 The block SHALL be a single module with no sub-module; the FSM and datapath SHALL be in one sequential process plus combinational decode.

Verification
REQ-031 Reset mid-count: load D=4'd9, 3 enabled edges, then reset=0 for one edge -> Q=0, busy=0, done=0, zero=1.
REQ-032 Basic count: load D=4'd5, enable=1 -> Q runs 5,4,3,2,1,0; done=1 for exactly one cycle on the 5th edge after load; then IDLE.
REQ-033 Enable gaps: load D=4'd3 with enable toggling 1,0,0,1,1 -> Q runs 3,2,2,2,1,0; done asserts after the 3rd enabled edge only.
REQ-034 Zero and full scale: load D=4'd0 -> done=1 on the next edge with busy never 1; load D=4'd15 -> 15 enabled edges to done, no wrap.
REQ-035 Abort and collision: load D=4'd6, 2 edges, abort=1 -> IDLE with Q=4; load D=4'd2 asserted on the Q==1 edge -> Q=2, done stays 0.
REQ-036 Auto-reload (macro defined): load D=4'd2 -> Q runs 2,1,0(done),2,1,0(done) repeatedly; abort=1 in DONE -> IDLE with Q=0.
